// File: rtl/rcv_bit_ctrl.sv
// UART receive bit-timing/control: line synchroniser, start-bit qualify,
// bit-centre shift strobes, stop-bit framing check and buffer-load pulse.
module rcv_bit_ctrl #(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic serial_in,
  input  logic stop_bit,
  output logic shift_strobe,
  output logic load_buffer,
  output logic framing_error,
  output logic rx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 2);

  // START decision is registered on the edge after the count reaches this,
  // so the outcome is visible at cycle CLKS_PER_BIT/2.
  localparam logic [CW-1:0] HALF_M2  = CW'(CLKS_PER_BIT / 2 - 2);
  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    RECEIVE,
    CHECK,
    LOAD
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic            strobe_q, strobe_d;
  logic            load_q, load_d;
  logic            fe_q, fe_d;
  logic            busy_q, busy_d;

  logic            meta_q, sync_q, prev_q;
  logic [2:0]      armed_q;
  logic            start_edge;

  // armed_q holds off edge detection until prev_q carries a real line sample,
  // so a line already low when reset releases is not taken as a start bit.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      prev_q  <= 1'b1;
      armed_q <= '0;
    end else begin
      meta_q  <= serial_in;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      armed_q <= {armed_q[1:0], 1'b1};
    end
  end

  assign start_edge = armed_q[2] & prev_q & ~sync_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      strobe_q  <= 1'b0;
      load_q    <= 1'b0;
      fe_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      strobe_q  <= strobe_d;
      load_q    <= load_d;
      fe_q      <= fe_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    strobe_d  = 1'b0;
    load_d    = 1'b0;
    fe_d      = fe_q;

    unique case (state_q)
      IDLE: begin
        if (start_edge) state_d = START;
      end

      START: begin
        if (clk_cnt_q == HALF_M2) begin
          clk_cnt_d = '0;
          if (!sync_q) begin
            state_d   = RECEIVE;
            bit_cnt_d = '0;
            fe_d      = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end

      RECEIVE: begin
        if (bit_cnt_q == BIT_LAST) begin
          state_d = CHECK;
        end else if (clk_cnt_q == CLK_LAST) begin
          strobe_d  = 1'b1;
          clk_cnt_d = '0;
          bit_cnt_d = bit_cnt_q + BW'(1);
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end

      CHECK: begin
        fe_d = ~stop_bit;
        if (stop_bit) begin
          state_d = LOAD;
          load_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      LOAD: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == IDLE) begin
      clk_cnt_d = '0;
      bit_cnt_d = '0;
    end

    busy_d = (state_d != IDLE);
  end

  assign shift_strobe  = strobe_q;
  assign load_buffer   = load_q;
  assign framing_error = fe_q;
  assign rx_busy       = busy_q;

endmodule

// File: tb/tb_rcv_bit_ctrl.sv
// Scoreboard bench for rcv_bit_ctrl with a small 9-bit receive shift register
// model supplying stop_bit and the captured packet.
module tb_rcv_bit_ctrl;

  localparam int CPB  = 10;
  localparam int DB   = 8;
  localparam int HALF = CPB / 2;

  logic clk = 1'b0;
  logic n_rst;
  logic serial_in;
  logic stop_bit;
  logic shift_strobe;
  logic load_buffer;
  logic framing_error;
  logic rx_busy;

  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [8:0]  sr = '0;

  typedef struct {
    bit          is_load;
    int unsigned cyc;
    logic [8:0]  sr;
  } exp_t;

  exp_t sbq[$];

  rcv_bit_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .serial_in    (serial_in),
    .stop_bit     (stop_bit),
    .shift_strobe (shift_strobe),
    .load_buffer  (load_buffer),
    .framing_error(framing_error),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (shift_strobe) sr <= {serial_in, sr[8:1]};
  assign stop_bit = sr[8];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // A spec "cycle n" output is sampled at edge e0+n, so it is visible just after edge e0+n-1.
  function automatic int unsigned vis(input int unsigned e0, input int unsigned n);
    return e0 + n - 1;
  endfunction

  task automatic wait_cyc(input int unsigned n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic sync_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input int unsigned e0, input logic [7:0] data, input bit loads);
    for (int k = 1; k <= DB + 1; k++)
      sbq.push_back('{1'b0, vis(e0, HALF + k * CPB), 9'h000});
    if (loads)
      sbq.push_back('{1'b1, vis(e0, HALF + (DB + 1) * CPB + 2), {1'b1, data}});
  endtask

  always @(negedge clk) begin
    if (shift_strobe || load_buffer) begin
      if (sbq.size() == 0) begin
        check_eq("spurious_pulse", {30'd0, shift_strobe, load_buffer}, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check_eq("pulse_kind", {30'd0, shift_strobe, load_buffer}, e.is_load ? 32'd1 : 32'd2);
        check_eq("pulse_cycle", cyc, e.cyc);
        if (e.is_load) check_eq("packet", {23'd0, sr}, {23'd0, e.sr});
      end
    end
  end

  // Expects to be entered just after a clock edge (or at the join of a previous frame).
  task automatic send_frame(input logic [7:0] data, input bit stop);
    int unsigned e0;
    logic [9:0]  bits;
    bits = {stop, data, 1'b0};
    e0   = cyc + 3;
    push_frame(e0, data, stop);
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          serial_in = bits[i];
          repeat (CPB) @(posedge clk);
          #1;
        end
      end
      begin
        wait_cyc(vis(e0, 1));
        check_eq("busy_start", rx_busy, 1);
        wait_cyc(vis(e0, HALF));
        check_eq("fe_cleared", framing_error, 0);
        wait_cyc(vis(e0, 96));
        check_eq("busy_in_check", rx_busy, 1);
        check_eq("fe_before_check", framing_error, 0);
        wait_cyc(vis(e0, 97));
        check_eq("fe_frame", framing_error, {31'd0, ~stop});
        wait_cyc(vis(e0, 98));
        check_eq("busy_end", rx_busy, 0);
      end
    join
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned e0;
    int unsigned t0;

    n_rst     = 1'b0;
    serial_in = 1'b1;
    #3;
    check_eq("rst_strobe", shift_strobe, 0);
    check_eq("rst_load", load_buffer, 0);
    check_eq("rst_fe", framing_error, 0);
    check_eq("rst_busy", rx_busy, 0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    repeat (5) @(posedge clk);

    // Reset mid-RECEIVE, then release with the line still low.
    sync_edge();
    e0 = cyc + 3;
    serial_in = 1'b0;
    for (int k = 1; k <= 3; k++) sbq.push_back('{1'b0, vis(e0, HALF + k * CPB), 9'h000});
    wait_cyc(vis(e0, 41));
    check_eq("busy_mid_rx", rx_busy, 1);
    #2 n_rst = 1'b0;
    #1;
    check_eq("arst_strobe", shift_strobe, 0);
    check_eq("arst_load", load_buffer, 0);
    check_eq("arst_fe", framing_error, 0);
    check_eq("arst_busy", rx_busy, 0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    repeat (50) @(negedge clk);
    check_eq("low_after_rst_busy", rx_busy, 0);
    check_eq("low_after_rst_sb", sbq.size(), 0);
    serial_in = 1'b1;
    repeat (10) @(posedge clk);

    // Good frame 0xA5.
    sync_edge();
    send_frame(8'hA5, 1'b1);
    serial_in = 1'b1;
    repeat (20) @(posedge clk);

    // Bad stop bit.
    sync_edge();
    send_frame(8'h3C, 1'b0);
    serial_in = 1'b1;
    repeat (20) @(posedge clk);

    // Start glitch: three low cycles, framing_error must stay set.
    sync_edge();
    e0 = cyc + 3;
    serial_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 serial_in = 1'b1;
    wait_cyc(vis(e0, 3));
    check_eq("glitch_busy", rx_busy, 1);
    wait_cyc(vis(e0, 5));
    check_eq("glitch_idle", rx_busy, 0);
    check_eq("glitch_fe_kept", framing_error, 1);
    repeat (30) @(posedge clk);

    // Back-to-back good frames with a single stop bit.
    sync_edge();
    send_frame(8'h5A, 1'b1);
    send_frame(8'hC3, 1'b1);
    serial_in = 1'b1;
    repeat (20) @(posedge clk);

    // Break: line low for 200 cycles.
    sync_edge();
    t0 = cyc;
    e0 = t0 + 3;
    serial_in = 1'b0;
    push_frame(e0, 8'h00, 1'b0);
    wait_cyc(vis(e0, 96));
    check_eq("break_fe_before", framing_error, 0);
    wait_cyc(vis(e0, 97));
    check_eq("break_fe", framing_error, 1);
    wait_cyc(vis(e0, 98));
    check_eq("break_busy_end", rx_busy, 0);
    wait_cyc(t0 + 200);
    check_eq("break_hold_busy", rx_busy, 0);
    serial_in = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    check_eq("break_recover_busy", rx_busy, 0);
    check_eq("break_recover_fe", framing_error, 1);

    check_eq("sb_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
